// File: rtl/irq_source.sv
// Three-channel button interrupt source: sync, debounce, rising-edge trigger, per-channel IRQ handshake FSM.
// Define IRQ_TIMER_EN to add a free-running timer whose wrap cycle is an extra channel-0 trigger.
module irq_source #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TIMER_PERIOD    = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] btn,
    input  logic [2:0] IRW,
    output logic [2:0] IRQ,
    output logic [2:0] busy,
    output logic [7:0] drop_cnt
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ASSERT,
        S_WAIT
    } state_t;

    logic [2:0]    r_sync1;
    logic [2:0]    r_sync2;
    logic [CW-1:0] r_cnt [3];
    logic [2:0]    r_lvl;
    logic [2:0]    r_lvl_d;
    state_t        r_state [3];
    logic [2:0]    r_irq;
    logic [2:0]    r_busy;
    logic [7:0]    r_drop;

    logic [2:0]    w_trig;
    logic [1:0]    w_ndrop;
    logic [8:0]    w_sum;
    logic [7:0]    w_drop_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_lvl   <= '0;
            r_lvl_d <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
            r_lvl_d <= r_lvl;
            for (int unsigned i = 0; i < 3; i++) begin
                if (r_sync2[i] != r_lvl[i]) begin
                    if (r_cnt[i] == CNT_MAX) begin
                        r_lvl[i] <= r_sync2[i];
                        r_cnt[i] <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

`ifdef IRQ_TIMER_EN
    localparam int unsigned TW = (TIMER_PERIOD > 1) ? $clog2(TIMER_PERIOD) : 1;
    localparam logic [TW-1:0] TMR_MAX = TW'(TIMER_PERIOD - 1);

    logic [TW-1:0] r_timer;
    logic          w_tick;

    assign w_tick = (r_timer == TMR_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timer <= '0;
        end else begin
            r_timer <= w_tick ? '0 : r_timer + 1'b1;
        end
    end

    // A timer wrap coinciding with a button edge is a single channel-0 event.
    assign w_trig = (r_lvl & ~r_lvl_d) | {2'b00, w_tick};
`else
    logic w_unused_period;
    assign w_unused_period = ^TIMER_PERIOD;
    assign w_trig          = r_lvl & ~r_lvl_d;
`endif

    // Every busy channel that sees a trigger drops it; this includes WAIT on its exit cycle.
    always_comb begin
        w_ndrop = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            w_ndrop = w_ndrop + {1'b0, w_trig[i] & r_busy[i]};
        end
        w_sum       = {1'b0, r_drop} + {7'b0, w_ndrop};
        w_drop_next = w_sum[8] ? '1 : w_sum[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_irq  <= '0;
            r_busy <= '0;
            r_drop <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                r_state[i] <= S_IDLE;
            end
        end else begin
            r_drop <= w_drop_next;
            for (int unsigned i = 0; i < 3; i++) begin
                case (r_state[i])
                    S_IDLE: begin
                        if (w_trig[i]) begin
                            r_state[i] <= S_ASSERT;
                            r_irq[i]   <= 1'b1;
                            r_busy[i]  <= 1'b1;
                        end
                    end
                    S_ASSERT: begin
                        if (IRW[i]) begin
                            r_state[i] <= S_WAIT;
                            r_irq[i]   <= 1'b0;
                        end
                    end
                    S_WAIT: begin
                        if (!IRW[i]) begin
                            r_state[i] <= S_IDLE;
                            r_busy[i]  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state[i] <= S_IDLE;
                        r_irq[i]   <= 1'b0;
                        r_busy[i]  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign IRQ      = r_irq;
    assign busy     = r_busy;
    assign drop_cnt = r_drop;

endmodule

// File: doc/irq_source.md
IRQ_SOURCE -- requirements
Module: irq_source

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles a synchronized button needs before its debounced level changes.
REQ-002 Parameter TIMER_PERIOD, default 1000: timer expiry interval in cycles; used only when IRQ_TIMER_EN is defined.
REQ-003 Port clk  input  1  single clock, shared with the CPU.
REQ-004 Port rst  input  1  asynchronous, active-low reset.
REQ-005 Port btn  input  3  raw asynchronous interrupt buttons, one per channel (bit 0 = lowest priority at the CPU).
REQ-006 Port IRW  input  3  CPU per-channel "request latched / waiting" flags, same clock domain.
REQ-007 Port IRQ  output  3  interrupt request lines to the CPU, registered.
REQ-008 Port busy  output  3  channel i is not in IDLE.
REQ-009 Port drop_cnt  output  8  saturating count of dropped trigger events, all channels combined.

Function
REQ-010 Each btn[i] SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 Each channel SHALL have its own debounce counter; the debounced level SHALL take the synchronized value only after that value differs from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-012 Any glitch shorter than DEBOUNCE_CYCLES SHALL reset the counter and SHALL NOT change the debounced level.
REQ-013 A trigger event SHALL be a rising edge of the debounced level (1-cycle pulse); falling edges SHALL NOT trigger.
REQ-014 Each channel SHALL have an independent FSM with states IDLE, ASSERT and WAIT.
REQ-015 In IDLE, a trigger event SHALL move the FSM to ASSERT; IRQ[i] SHALL be 1 in ASSERT only.
REQ-016 In ASSERT, sampling IRW[i]=1 SHALL move the FSM to WAIT, with IRQ[i] dropping on that same edge.
REQ-017 In WAIT, sampling IRW[i]=0 SHALL move the FSM to IDLE.
REQ-018 Latency: with btn[i] held high and counting the first edge that samples it as edge 1, IRQ[i] SHALL first be 1 after edge 3+DEBOUNCE_CYCLES.
REQ-019 A trigger event on a channel not in IDLE SHALL be dropped: no state change, drop_cnt+1, saturating at 255.
REQ-020 A trigger event in the same cycle as the WAIT->IDLE transition SHALL be dropped.
REQ-021 Simultaneous drops on k channels SHALL add k to drop_cnt in one cycle, saturating.
REQ-022 Channels SHALL be fully independent; simultaneous triggers on several channels SHALL assert the corresponding IRQ bits on the same edge.
REQ-023 IRW[i] already 1 while the FSM is in IDLE SHALL be ignored.

Reset
REQ-024 Asserting rst (low) SHALL asynchronously force: all FSMs to IDLE, IRQ=0, busy=0, drop_cnt=0, synchronizers, debounce counters and debounced levels to 0, timer to 0.
REQ-025 Reset during ASSERT SHALL drop IRQ immediately, without waiting for a clock edge.
REQ-026 A button held high across reset release SHALL generate exactly one trigger after REQ-018 latency, counted from the first post-release edge.

Configuration
REQ-027 Macro IRQ_TIMER_EN defined: a free-running counter SHALL count 0..TIMER_PERIOD-1 and wrap.
REQ-028 With IRQ_TIMER_EN defined, the wrap cycle SHALL be an extra channel-0 trigger, ORed with the button trigger; if both occur in one cycle, they count as one event.
REQ-029 Macro IRQ_TIMER_EN undefined: no timer logic; channel 0 is button-only and TIMER_PERIOD is ignored.

Verification
REQ-030 DEBOUNCE_CYCLES=4; btn=3'b001 held; IRW=0 -> IRQ=3'b001 first after edge 7; busy[0]=1.
REQ-031 During ASSERT, drive IRW[0]=1 for 5 cycles, then 0 -> IRQ[0] falls on the first edge sampling IRW[0]=1; busy[0] falls one edge after IRW[0]=0.
REQ-032 btn[1] pulse 3 cycles long -> no IRQ[1], drop_cnt=0; repeat with a 6-cycle pulse -> IRQ[1] asserts.
REQ-033 While channel 2 is in WAIT, issue 300 debounced button-2 presses -> drop_cnt saturates at 255 and FSM2 stays in WAIT.
REQ-034 btn=3'b111 rising together -> IRQ=3'b111 on the same edge; rst pulled low mid-ASSERT -> IRQ=0 immediately and drop_cnt=0.
REQ-035 With IRQ_TIMER_EN, TIMER_PERIOD=50, IRW handshake completing within 10 cycles -> IRQ[0] rises every 50 cycles and drop_cnt stays 0.
